// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory access arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [BE_W-1:0] BE_ALL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_e;

    // Transfer payload latched at grant time and replayed onto the bus.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              we;
    } mem_req_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Two-requester round-robin pick: a lone requester wins, a tie goes to the
// port that did not win last time.
module rr_grant_select
    import mem_arb_pkg::*;
(
    input  logic   i_if_req,
    input  logic   i_d_req,
    input  grant_e i_last_grant,
    output grant_e o_grant_c
);

    always_comb begin
        o_grant_c = GRANT_IF;
        if (i_d_req && !i_if_req) begin
            o_grant_c = GRANT_D;
        end else if (i_d_req && i_if_req) begin
            o_grant_c = (i_last_grant == GRANT_IF) ? GRANT_D : GRANT_IF;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one Avalon-MM
// master, one transfer at a time, round-robin on simultaneous requests.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BE_W-1:0]   d_byteenable,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [BE_W-1:0]   avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic              stall,
    output logic [BE_W-1:0]   active_byteenable
);

    // Seeding last_grant with the opposite port makes DATA_FIRST win the first tie.
    localparam grant_e LAST_GRANT_RST = DATA_FIRST ? GRANT_IF : GRANT_D;

    arb_state_e        r_state;
    grant_e            r_grant;
    grant_e            r_last_grant;
    mem_req_t          r_req;
    logic              r_avm_read;
    logic              r_avm_write;
    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [BE_W-1:0]   r_active_be;

    grant_e            w_grant;
    mem_req_t          w_if_pl;
    mem_req_t          w_d_pl;
    mem_req_t          w_sel_pl;
    logic              w_any_req;

    rr_grant_select u_rr_grant_select (
        .i_if_req     (if_req),
        .i_d_req      (d_req),
        .i_last_grant (r_last_grant),
        .o_grant_c    (w_grant)
    );

    assign w_any_req = if_req | d_req;
    assign w_if_pl   = '{addr: word_align(if_addr), be: BE_ALL, wdata: '0, we: 1'b0};
    assign w_d_pl    = '{addr: word_align(d_addr), be: d_byteenable, wdata: d_wdata, we: d_we};
    assign w_sel_pl  = (w_grant == GRANT_D) ? w_d_pl : w_if_pl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= GRANT_IF;
            r_last_grant <= LAST_GRANT_RST;
            r_req        <= '0;
            r_avm_read   <= 1'b0;
            r_avm_write  <= 1'b0;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_active_be  <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        // An empty lane mask has nothing to move: ack without touching the bus.
                        if ((w_grant == GRANT_D) && (d_byteenable == '0)) begin
                            r_d_ack     <= 1'b1;
                            r_active_be <= '0;
                            r_state     <= RESP;
                        end else begin
                            r_req       <= w_sel_pl;
                            r_avm_read  <= ~w_sel_pl.we;
                            r_avm_write <= w_sel_pl.we;
                            r_state     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!avm_waitrequest) begin
                        r_avm_read  <= 1'b0;
                        r_avm_write <= 1'b0;
                        r_active_be <= r_req.be;
                        r_state     <= RESP;
                        if (r_grant == GRANT_D) begin
                            r_d_ack <= 1'b1;
                            if (!r_req.we) begin
                                r_d_rdata <= avm_readdata;
                            end
                        end else begin
                            r_if_ack <= 1'b1;
                            if (!r_req.we) begin
                                r_if_rdata <= avm_readdata;
                            end
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign avm_address       = r_req.addr;
    assign avm_byteenable    = r_req.be;
    assign avm_writedata     = r_req.wdata;
    assign avm_read          = r_avm_read;
    assign avm_write         = r_avm_write;
    assign if_ack            = r_if_ack;
    assign d_ack             = r_d_ack;
    assign if_rdata          = r_if_rdata;
    assign d_rdata           = r_d_rdata;
    assign active_byteenable = r_active_be;
    assign stall             = (if_req & ~r_if_ack) | (d_req & ~r_d_ack);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized bench for mem_access_arbiter against a transaction-level model
// with a behavioural Avalon slave memory.
module tb_mem_access_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } tx_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_byteenable;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        stall;
    logic [3:0]  active_byteenable;

    mem_access_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_rdata          (if_rdata),
        .if_ack            (if_ack),
        .d_req             (d_req),
        .d_we              (d_we),
        .d_addr            (d_addr),
        .d_byteenable      (d_byteenable),
        .d_wdata           (d_wdata),
        .d_rdata           (d_rdata),
        .d_ack             (d_ack),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .stall             (stall),
        .active_byteenable (active_byteenable)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Port 0 = instruction fetch, port 1 = data.
    tx_t         q_if[$];
    tx_t         q_d[$];
    int          wait_q[$];
    int          win_log[$];
    tx_t         cur[2];
    bit          has_tx[2];
    bit          granted[2];
    bit          ack_prev[2];
    int          gap[2];
    logic [31:0] m_rdata[2];
    logic [31:0] mem[16];
    bit          gen_random = 1'b0;
    int          gap_max = 0;
    int          wait_max = 0;
    int          cyc = 0;
    bit          m_idle = 1'b1;
    int          exp_port = 0;
    int          dec_cycle = 0;
    int          last_win = 0;
    bit          in_xfer = 1'b0;
    tx_t         xt;
    logic [69:0] snap;
    int          waits_left = 0;
    int          waits_used = 0;
    int          xfer_cnt = 0;
    int          xfer_at_dec = 0;
    logic [31:0] first_addr_seen;

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic tx_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata);
        tx_t t;
        t.we    = we;
        t.addr  = addr;
        t.be    = be;
        t.wdata = wdata;
        return t;
    endfunction

    task automatic load_next(input int p);
        tx_t t;
        if (p == 0 && q_if.size() > 0) begin
            cur[0] = q_if.pop_front();
            has_tx[0] = 1'b1;
        end else if (p == 1 && q_d.size() > 0) begin
            cur[1] = q_d.pop_front();
            has_tx[1] = 1'b1;
        end else if (gen_random) begin
            t.addr  = 32'h2000_0000 | 32'($urandom_range(0, 63));
            t.wdata = $urandom;
            if (p == 0) begin
                t.we = 1'b0;
                t.be = 4'hF;
            end else begin
                t.we = 1'($urandom_range(0, 1));
                t.be = 4'($urandom_range(0, 15));
            end
            cur[p] = t;
            has_tx[p] = 1'b1;
        end
    endtask

    // Once a port is granted its side-band inputs are scrambled; the DUT must not care.
    task automatic drive();
        if_req = has_tx[0];
        if_addr = granted[0] ? $urandom : cur[0].addr;
        d_req = has_tx[1];
        if (granted[1]) begin
            d_we         = 1'($urandom_range(0, 1));
            d_addr       = $urandom;
            d_byteenable = 4'($urandom_range(0, 15));
            d_wdata      = $urandom;
        end else begin
            d_we         = cur[1].we;
            d_addr       = cur[1].addr;
            d_byteenable = cur[1].be;
            d_wdata      = cur[1].wdata;
        end
    endtask

    task automatic decide();
        if (m_idle && (has_tx[0] || has_tx[1])) begin
            if (has_tx[0] && has_tx[1]) exp_port = 1 - last_win;
            else exp_port = has_tx[1] ? 1 : 0;
            m_idle = 1'b0;
            dec_cycle = cyc;
            xfer_at_dec = xfer_cnt;
            granted[exp_port] = 1'b1;
        end
    endtask

    task automatic observe_acks();
        int p;
        bit zero;
        int lat;
        if (!(if_ack || d_ack)) return;
        check_val("dual_ack", 72'(if_ack & d_ack), 72'(0));
        p = d_ack ? 1 : 0;
        check_val("ack_port", 72'(p), m_idle ? 72'(2) : 72'(exp_port));
        if (m_idle) return;
        zero = (p == 1) && (cur[1].be == 4'h0);
        lat = zero ? 1 : 2 + waits_used;
        check_val("ack_latency", 72'(cyc - dec_cycle), 72'(lat));
        check_val("xfer_count", 72'(xfer_cnt - xfer_at_dec), zero ? 72'(0) : 72'(1));
        if (!zero && !cur[p].we) m_rdata[p] = mem[cur[p].addr[5:2]];
        check_val("if_rdata", 72'(if_rdata), 72'(m_rdata[0]));
        check_val("d_rdata", 72'(d_rdata), 72'(m_rdata[1]));
        check_val("active_be", 72'(active_byteenable), 72'(cur[p].be));
        ack_prev[p] = 1'b1;
        granted[p]  = 1'b0;
        last_win    = p;
        win_log.push_back(p);
        m_idle = 1'b1;
    endtask

    task automatic slave();
        if (avm_read || avm_write) begin
            if (!in_xfer) begin
                in_xfer = 1'b1;
                xfer_cnt++;
                xt = cur[exp_port];
                if (xfer_cnt == 1) first_addr_seen = avm_address;
                check_val("strobe_delay", 72'(cyc - dec_cycle), 72'(1));
                check_val("avm_address", 72'(avm_address), 72'(xt.addr & 32'hFFFF_FFFC));
                check_val("avm_be", 72'(avm_byteenable), 72'(xt.be));
                check_val("avm_rw", 72'({avm_read, avm_write}), 72'({~xt.we, xt.we}));
                if (xt.we) check_val("avm_wdata", 72'(avm_writedata), 72'(xt.wdata));
                snap = {avm_address, avm_byteenable, avm_read, avm_write, avm_writedata};
                waits_left = (wait_q.size() > 0) ? wait_q.pop_front() : int'($urandom_range(0, wait_max));
                waits_used = waits_left;
            end else begin
                check_val("avm_stable", 72'({avm_address, avm_byteenable, avm_read, avm_write,
                                             avm_writedata}), 72'(snap));
            end
            if (waits_left > 0) begin
                avm_waitrequest = 1'b1;
                avm_readdata = $urandom;
                waits_left--;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata = mem[avm_address[5:2]];
                if (xt.we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (xt.be[i]) mem[xt.addr[5:2]][8*i +: 8] = xt.wdata[8*i +: 8];
                    end
                end
                in_xfer = 1'b0;
            end
        end else begin
            avm_waitrequest = 1'($urandom_range(0, 1));
            avm_readdata = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < 2; p++) begin
            if (ack_prev[p]) begin
                ack_prev[p] = 1'b0;
                has_tx[p] = 1'b0;
                gap[p] = int'($urandom_range(0, gap_max));
            end
            if (!has_tx[p]) begin
                if (gap[p] > 0) gap[p]--;
                else load_next(p);
            end
        end
        drive();
        decide();
        observe_acks();
        slave();
        #1;
        check_val("stall", 72'(stall), 72'((if_req & ~if_ack) | (d_req & ~d_ack)));
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (n < budget && (q_if.size() > 0 || q_d.size() > 0 || has_tx[0] || has_tx[1] || !m_idle)) begin
            step();
            n++;
        end
        check_val("drain_timeout", 72'(n >= budget), 72'(0));
    endtask

    task automatic reset_model();
        in_xfer = 1'b0;
        waits_left = 0;
        m_idle = 1'b1;
        last_win = 0;
        avm_waitrequest = 1'b0;
        for (int p = 0; p < 2; p++) begin
            m_rdata[p]  = '0;
            granted[p]  = 1'b0;
            ack_prev[p] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_avm", 72'({avm_read, avm_write, avm_address, avm_byteenable, avm_writedata}), 72'(0));
        check_val("rst_acks", 72'({if_ack, d_ack}), 72'(0));
        check_val("rst_rdata", 72'({if_rdata, d_rdata}), 72'(0));
        check_val("rst_active_be", 72'(active_byteenable), 72'(0));
        reset_model();
        wait_q.delete();
        win_log.delete();
        for (int p = 0; p < 2; p++) begin
            has_tx[p] = 1'b0;
            gap[p] = 0;
        end
        drive();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset lands while a transfer is stalled; the requester keeps its request up.
    task automatic reset_mid();
        rst_n = 1'b0;
        #1;
        check_val("midrst_strobes", 72'({avm_read, avm_write}), 72'(0));
        check_val("midrst_acks", 72'({if_ack, d_ack}), 72'(0));
        check_val("midrst_rdata", 72'({if_rdata, d_rdata}), 72'(0));
        check_val("midrst_active_be", 72'(active_byteenable), 72'(0));
        reset_model();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        drive();
        rst_n = 1'b1;
        decide();
    endtask

    initial begin
        int n;
        int d_acks_before;
        if_req = 1'b0;
        d_req = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        first_addr_seen = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int p = 0; p < 2; p++) cur[p] = mk(1'b0, 32'h0, 4'hF, 32'h0);
        drive();

        do_reset();
        xfer_cnt = 0;
        q_if.push_back(mk(1'b0, 32'hBFC0_0003, 4'hF, 32'h0));
        wait_q.push_back(0);
        run_until_done(50);
        check_val("fetch_aligned_addr", 72'(first_addr_seen), 72'(32'hBFC0_0000));

        do_reset();
        q_if.push_back(mk(1'b0, 32'h2000_0004, 4'hF, 32'h0));
        q_if.push_back(mk(1'b0, 32'h2000_0014, 4'hF, 32'h0));
        q_d.push_back(mk(1'b0, 32'h2000_0008, 4'hF, 32'h0));
        q_d.push_back(mk(1'b0, 32'h2000_0030, 4'hF, 32'h0));
        gap_max = 0;
        run_until_done(100);
        check_val("rr_first", 72'(win_log.size() > 0 ? win_log[0] : 9), 72'(1));
        check_val("rr_second", 72'(win_log.size() > 1 ? win_log[1] : 9), 72'(0));
        check_val("rr_third", 72'(win_log.size() > 2 ? win_log[2] : 9), 72'(1));

        q_d.push_back(mk(1'b1, 32'h2000_0010, 4'b0100, 32'h00AB_0000));
        wait_q.push_back(3);
        run_until_done(50);
        q_d.push_back(mk(1'b0, 32'h2000_0010, 4'hF, 32'h0));
        wait_q.push_back(0);
        run_until_done(50);

        q_d.push_back(mk(1'b0, 32'h2000_0024, 4'h0, 32'h0));
        run_until_done(50);

        q_d.push_back(mk(1'b0, 32'h2000_0008, 4'hF, 32'h0));
        wait_q.push_back(3);
        n = 0;
        while (!(in_xfer && waits_left > 0) && n < 20) begin
            step();
            n++;
        end
        check_val("midrst_reached_busy", 72'(n < 20), 72'(1));
        d_acks_before = win_log.size();
        reset_mid();
        run_until_done(50);
        check_val("midrst_reserved", 72'(win_log.size() - d_acks_before), 72'(1));

        gen_random = 1'b1;
        gap_max = 3;
        wait_max = 3;
        repeat (3000) step();
        gen_random = 1'b0;
        run_until_done(200);

        gen_random = 1'b1;
        gap_max = 0;
        wait_max = 2;
        repeat (2000) step();
        gen_random = 1'b0;
        run_until_done(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
